// File: rtl/metro_pkg.sv
// Shared types and defaults for the metro ticket-print arbiter.
package metro_pkg;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_PRINT,
    S_WAIT,
    S_ACK,
    S_ERR
  } state_t;

  typedef logic [1:0] kiosk_t;
  typedef logic [1:0] dest_t;
  typedef logic [1:0] cnt_t;

endpackage

// File: rtl/metro_print_arbiter_if.sv
// Kiosk/printer bundle between the booking side and the arbiter.
interface metro_print_arbiter_if;
  import metro_pkg::*;

  kiosk_t req;
  dest_t  dest0;
  dest_t  dest1;
  cnt_t   cnt0;
  cnt_t   cnt1;
  kiosk_t grant;
  logic   prn_start;
  dest_t  prn_dest;
  logic   prn_done;
  kiosk_t ack;
  cnt_t   issued;
  logic   err;

  modport master (
    output req, dest0, dest1, cnt0, cnt1, prn_done,
    input  grant, prn_start, prn_dest, ack, issued, err
  );

  modport slave (
    input  req, dest0, dest1, cnt0, cnt1, prn_done,
    output grant, prn_start, prn_dest, ack, issued, err
  );

endinterface

// File: rtl/prn_watchdog.sv
// Per-ticket WAIT timer; expired fires on the cycle the count reaches TIMEOUT.
module prn_watchdog
  import metro_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic arst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TOP  = TW'(TIMEOUT);

  logic [TW-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (clear) begin
      tmr_d = '0;
    end else if (enable && tmr_q != TOP) begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  assign expired = enable && (tmr_q == LAST);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) tmr_q <= '0;
    else      tmr_q <= tmr_d;
  end

endmodule

// File: rtl/metro_print_arbiter.sv
// Round-robin arbiter sharing one ticket printer between two kiosks.
module metro_print_arbiter
  import metro_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic arst,
  metro_print_arbiter_if.slave bus
);

  state_t state_q, state_d;
  kiosk_t win_q, win_d;
  kiosk_t prio_q, prio_d;
  dest_t  dest_q, dest_d;
  cnt_t   rem_q, rem_d;
  cnt_t   iss_q, iss_d;

  kiosk_t pick;
  dest_t  sel_dest;
  cnt_t   sel_cnt;
  logic   wd_clear, wd_en, wd_exp;
  logic   fin;

  // Contention resolves to the kiosk holding priority.
  assign pick     = (bus.req == 2'b11) ? prio_q : bus.req;
  assign sel_dest = win_q[1] ? bus.dest1 : bus.dest0;
  assign sel_cnt  = win_q[1] ? bus.cnt1 : bus.cnt0;

  assign wd_clear = (state_q == S_PRINT);
  assign wd_en    = (state_q == S_WAIT) && !bus.prn_done;

  prn_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .arst    (arst),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_exp)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    prio_d  = prio_q;
    dest_d  = dest_q;
    rem_d   = rem_q;
    iss_d   = iss_q;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          win_d   = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        dest_d  = sel_dest;
        rem_d   = sel_cnt;
        iss_d   = '0;
        state_d = (sel_cnt == 2'd0) ? S_ACK : S_PRINT;
      end
      S_PRINT: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.prn_done) begin
          iss_d   = iss_q + 2'd1;
          rem_d   = rem_q - 2'd1;
          state_d = (rem_q == 2'd1) ? S_ACK : S_PRINT;
        end else if (wd_exp) begin
          state_d = S_ERR;
        end
      end
      S_ACK, S_ERR: begin
        prio_d  = ~win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      prio_q  <= 2'b01;
      dest_q  <= '0;
      rem_q   <= '0;
      iss_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      prio_q  <= prio_d;
      dest_q  <= dest_d;
      rem_q   <= rem_d;
      iss_q   <= iss_d;
    end
  end

  assign fin           = (state_q == S_ACK) || (state_q == S_ERR);
  assign bus.grant     = (state_q != S_IDLE) ? win_q : '0;
  assign bus.prn_start = (state_q == S_PRINT);
  assign bus.prn_dest  = bus.prn_start ? dest_q : '0;
  assign bus.ack       = fin ? win_q : '0;
  assign bus.issued    = fin ? iss_q : '0;
  assign bus.err       = (state_q == S_ERR);

endmodule

// File: tb/tb_metro_print_arbiter.sv
// Scoreboard bench for metro_print_arbiter with a delayed-done printer model.
module tb_metro_print_arbiter;
  import metro_pkg::*;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  metro_print_arbiter_if bus();

  metro_print_arbiter #(.TIMEOUT(16)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] ack;
    logic [1:0] iss;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int vec  = 0;
  int miss = 0;

  logic   got;
  exp_t   obs;
  exp_t   want;
  int     starts, first_start, last_start, ack_c;
  logic   dest_ok;
  kiosk_t gnt;

  // Printer model + monitor: answers each start with done after dly cycles.
  task automatic serve(input int budget, input int dly, input int max_done,
                       input logic [1:0] exp_dest, input int drop_c);
    int cd;
    int dones;
    cd = -1; dones = 0;
    got = 1'b0; obs = '0; starts = 0;
    first_start = -1; last_start = -1; ack_c = -1;
    dest_ok = 1'b1; gnt = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      bus.prn_done = 1'b0;
      if (gnt == 2'b00) gnt = bus.grant;
      if (bus.ack != 2'b00) begin
        got = 1'b1;
        obs = '{ack: bus.ack, iss: bus.issued, err: bus.err};
        ack_c = c;
        break;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.prn_done = 1'b1;
          dones++;
          cd = -1;
        end
      end
      if (bus.prn_start) begin
        starts++;
        if (first_start < 0) first_start = c;
        last_start = c;
        if (bus.prn_dest !== exp_dest) dest_ok = 1'b0;
        if (dones < max_done) cd = dly;
      end
      if (c == drop_c - 1) bus.prn_done = 1'b1;
      if (c == drop_c) begin
        bus.req   = 2'b00;
        bus.dest0 = 2'd3;
        bus.cnt0  = 2'd0;
      end
    end
  endtask

  task automatic pop_want();
    if (exp_q.size() > 0) want = exp_q.pop_front();
    else want = 'x;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    bus.req = 2'b11; bus.dest0 = 2'd1; bus.dest1 = 2'd2;
    bus.cnt0 = 2'd1; bus.cnt1 = 2'd1; bus.prn_done = 1'b0;
    #1;
    vec++;
    if ({bus.grant, bus.prn_start, bus.prn_dest, bus.ack, bus.issued, bus.err} !== 10'd0) begin
      miss++;
      $display("FAIL reset_outputs got=%b want=0",
        {bus.grant, bus.prn_start, bus.prn_dest, bus.ack, bus.issued, bus.err});
    end
    repeat (3) @(negedge clk);
    vec++;
    if (bus.grant !== 2'b00) begin
      miss++;
      $display("FAIL reset_hold_grant got=%b want=00", bus.grant);
    end
    bus.req = 2'b00;
    arst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    bus.dest0 = 2'd0; bus.dest1 = 2'd3;
    bus.cnt0 = 2'd1; bus.cnt1 = 2'd2;
    bus.req = 2'b11;
    exp_q.push_back('{ack: 2'b01, iss: 2'd1, err: 1'b0});
    exp_q.push_back('{ack: 2'b10, iss: 2'd2, err: 1'b0});
    serve(60, 2, 4, 2'd0, -1);
    bus.req = 2'b10;
    pop_want();
    vec++;
    if (!got || obs !== want || gnt !== 2'b01 || starts != 1 || !dest_ok) begin
      miss++;
      $display("FAIL contention_k0 got=%b obs=%b gnt=%b starts=%0d dok=%b want=%b gnt=01 starts=1",
        got, obs, gnt, starts, dest_ok, want);
    end
    serve(60, 2, 4, 2'd3, -1);
    bus.req = 2'b00;
    pop_want();
    vec++;
    if (!got || obs !== want || gnt !== 2'b10 || starts != 2 || !dest_ok) begin
      miss++;
      $display("FAIL contention_k1 got=%b obs=%b gnt=%b starts=%0d dok=%b want=%b gnt=10 starts=2",
        got, obs, gnt, starts, dest_ok, want);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bus.prn_done = 1'b1;
    repeat (3) @(negedge clk);
    bus.prn_done = 1'b0;
    bus.dest0 = 2'd2; bus.cnt0 = 2'd3;
    bus.req = 2'b01;
    exp_q.push_back('{ack: 2'b01, iss: 2'd3, err: 1'b0});
    serve(100, 3, 4, 2'd2, -1);
    bus.req = 2'b00;
    pop_want();
    vec++;
    if (!got || obs !== want || starts != 3 || !dest_ok) begin
      miss++;
      $display("FAIL single got=%b obs=%b starts=%0d dok=%b want=%b starts=3",
        got, obs, starts, dest_ok, want);
    end
    vec++;
    if (first_start != 1 || ack_c - last_start != 4) begin
      miss++;
      $display("FAIL single_latency first=%0d tail=%0d want first=1 tail=4",
        first_start, ack_c - last_start);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero();
    bus.dest1 = 2'd1; bus.cnt1 = 2'd0;
    bus.req = 2'b10;
    exp_q.push_back('{ack: 2'b10, iss: 2'd0, err: 1'b0});
    serve(20, 2, 4, 2'd1, -1);
    bus.req = 2'b00;
    pop_want();
    vec++;
    if (!got || obs !== want || starts != 0 || ack_c != 1) begin
      miss++;
      $display("FAIL zero_count got=%b obs=%b starts=%0d ackc=%0d want=%b starts=0 ackc=1",
        got, obs, starts, ack_c, want);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bus.dest0 = 2'd1; bus.cnt0 = 2'd2;
    bus.req = 2'b01;
    exp_q.push_back('{ack: 2'b01, iss: 2'd1, err: 1'b1});
    serve(100, 2, 1, 2'd1, -1);
    bus.req = 2'b00;
    pop_want();
    vec++;
    if (!got || obs !== want || starts != 2) begin
      miss++;
      $display("FAIL timeout got=%b obs=%b starts=%0d want=%b starts=2",
        got, obs, starts, want);
    end
    vec++;
    if (ack_c - last_start != 17) begin
      miss++;
      $display("FAIL timeout_len got=%0d want=17", ack_c - last_start);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_race();
    bus.dest0 = 2'd3; bus.cnt0 = 2'd1;
    bus.req = 2'b01;
    exp_q.push_back('{ack: 2'b01, iss: 2'd1, err: 1'b0});
    serve(100, 16, 1, 2'd3, -1);
    bus.req = 2'b00;
    pop_want();
    vec++;
    if (!got || obs !== want || ack_c - last_start != 17 || !dest_ok) begin
      miss++;
      $display("FAIL race got=%b obs=%b tail=%0d dok=%b want=%b tail=17",
        got, obs, ack_c - last_start, dest_ok, want);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop();
    bus.dest0 = 2'd1; bus.cnt0 = 2'd2;
    bus.req = 2'b01;
    exp_q.push_back('{ack: 2'b01, iss: 2'd2, err: 1'b0});
    serve(80, 2, 4, 2'd1, 2);
    bus.req = 2'b00;
    pop_want();
    vec++;
    if (!got || obs !== want || starts != 2 || !dest_ok) begin
      miss++;
      $display("FAIL drop_req got=%b obs=%b starts=%0d dok=%b want=%b starts=2",
        got, obs, starts, dest_ok, want);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.dest0 = 2'd2; bus.cnt0 = 2'd3;
    bus.req = 2'b01;
    serve(5, 3, 0, 2'd2, -1);
    vec++;
    if (got || bus.grant !== 2'b01) begin
      miss++;
      $display("FAIL pre_reset_wait ack=%b grant=%b want ack=0 grant=01", got, bus.grant);
    end
    #2 arst = 1'b1;
    #1;
    vec++;
    if ({bus.grant, bus.prn_start, bus.prn_dest, bus.ack, bus.issued, bus.err} !== 10'd0) begin
      miss++;
      $display("FAIL async_reset got=%b want=0",
        {bus.grant, bus.prn_start, bus.prn_dest, bus.ack, bus.issued, bus.err});
    end
    bus.req = 2'b00;
    @(negedge clk);
    arst = 1'b0;
    bus.dest1 = 2'd2; bus.cnt1 = 2'd1;
    bus.req = 2'b10;
    exp_q.push_back('{ack: 2'b10, iss: 2'd1, err: 1'b0});
    serve(60, 2, 4, 2'd2, -1);
    bus.req = 2'b00;
    pop_want();
    vec++;
    if (!got || obs !== want || gnt !== 2'b10 || starts != 1 || !dest_ok) begin
      miss++;
      $display("FAIL post_reset got=%b obs=%b gnt=%b starts=%0d dok=%b want=%b gnt=10 starts=1",
        got, obs, gnt, starts, dest_ok, want);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_zero();
    test_timeout();
    test_race();
    test_drop();
    test_reset_mid();
    vec++;
    if (exp_q.size() != 0) begin
      miss++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
